// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard detection driven by a shadow pipeline
// of in-flight register writers, one entry per stage from EX to WB.
module fwd_hazard_unit #(
  parameter int ADDR_W     = 5,
  parameter int NREAD      = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int ZERO_REG   = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [ADDR_W-1:0]       id_rd,
  input  logic                    id_we,
  input  logic                    id_is_load,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  input  logic [NREAD-1:0]        rd_used,
  input  logic                    hold,
  input  logic                    flush,
  output logic [NREAD*SEL_W-1:0]  fwd_sel,
  output logic                    load_use_stall,
  output logic [31:0]             stall_cnt
);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] rd;
    logic              we;
    logic              ld;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  entry_t      ent_q [DEPTH];
  entry_t      ent_d [DEPTH];
  logic [31:0] cnt_q, cnt_d;
  logic [NREAD-1:0] port_hazard;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic              hit_ld;
    logic              hit_early;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Scan oldest to youngest so the last hit, the youngest writer, wins.
    always_comb begin
      // NOTE: every output of a combinational block gets a default first; a
      // path that leaves one unassigned would infer a latch.
      sel       = '0;
      hit_ld    = 1'b0;
      hit_early = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_q[k].v && ent_q[k].we && (ent_q[k].rd == addr) &&
            !((ZERO_REG != 0) && (addr == '0))) begin
          sel       = SEL_W'(k + 1);
          hit_ld    = ent_q[k].ld;
          hit_early = (k < LOAD_READY);
        end
      end
    end

    assign fwd_sel[p*SEL_W +: SEL_W] = sel;
    assign port_hazard[p]            = rd_used[p] & hit_ld & hit_early;
  end

  assign load_use_stall = id_valid & (|port_hazard) & ~hold & ~flush;
  assign stall_cnt      = cnt_q;

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (hold) begin
      ent_d = ent_q;
    end else if (flush) begin
      // Flush kills both the ID instruction and the one now in EX.
      ent_d[0] = BUBBLE;
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k] = (k == 1) ? BUBBLE : ent_q[k-1];
      end
    end else begin
      ent_d[0] = load_use_stall ? BUBBLE
                                : '{v: id_valid, rd: id_rd, we: id_we, ld: id_is_load};
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k] = ent_q[k-1];
      end
      if (load_use_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_q[k] <= BUBBLE;
      end
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit at default parameters: each step drives
// one ID cycle and queues the hand-derived outputs expected in that cycle.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_we = 1'b0;
  logic        id_is_load = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  rd_used = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  fwd_sel;
  logic        load_use_stall;
  logic [31:0] stall_cnt;

  typedef struct {
    int          id;
    logic [1:0]  s0;
    logic [1:0]  s1;
    logic        st;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb [$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  fwd_hazard_unit dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rd          (id_rd),
    .id_we          (id_we),
    .id_is_load     (id_is_load),
    .rd_addr        (rd_addr),
    .rd_used        (rd_used),
    .hold           (hold),
    .flush          (flush),
    .fwd_sel        (fwd_sel),
    .load_use_stall (load_use_stall),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of ID-stage inputs and queue the outputs expected while
  // they are applied (before the next rising edge updates the state).
  task automatic step(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used,
                      input logic h, input logic f, input logic r,
                      input logic [1:0] e0, input logic [1:0] e1, input logic es,
                      input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid   = v;
    id_rd      = rd;
    id_we      = we;
    id_is_load = ld;
    rd_addr    = {a1, a0};
    rd_used    = used;
    hold       = h;
    flush      = f;
    rst        = r;
    step_id++;
    e.id  = step_id;
    e.s0  = e0;
    e.s1  = e1;
    e.st  = es;
    e.cnt = ec;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check($sformatf("c%0d.sel0", cur.id),  {30'b0, fwd_sel[1:0]},   {30'b0, cur.s0});
      check($sformatf("c%0d.sel1", cur.id),  {30'b0, fwd_sel[3:2]},   {30'b0, cur.s1});
      check($sformatf("c%0d.stall", cur.id), {31'b0, load_use_stall}, {31'b0, cur.st});
      check($sformatf("c%0d.cnt", cur.id),   stall_cnt,               cur.cnt);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    //    v rd we ld  a0 a1 used  h  f  r   e0 e1 st cnt
    // reset state
    step(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0);
    // back-to-back ALU: EX, MEM, WB forwarding then gone
    step(1, 5, 1, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0);
    step(0, 0, 0, 0,  5, 0, 2'b01, 0, 0, 0,  1, 0, 0, 0);
    step(0, 0, 0, 0,  5, 0, 2'b01, 0, 0, 0,  2, 0, 0, 0);
    step(0, 0, 0, 0,  5, 0, 2'b01, 0, 0, 0,  3, 0, 0, 0);
    step(0, 0, 0, 0,  5, 0, 2'b01, 0, 0, 0,  0, 0, 0, 0);
    // youngest writer wins
    step(1, 5, 1, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0);
    step(1, 5, 1, 0,  5, 5, 2'b00, 0, 0, 0,  1, 1, 0, 0);
    step(0, 0, 0, 0,  5, 5, 2'b11, 0, 0, 0,  1, 1, 0, 0);
    step(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0);
    step(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0);
    // load-use: one stall cycle then forward from MEM
    step(1, 7, 1, 1,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0);
    step(1, 8, 1, 0,  0, 7, 2'b10, 0, 0, 0,  0, 1, 1, 0);
    step(1, 8, 1, 0,  0, 7, 2'b10, 0, 0, 0,  0, 2, 0, 1);
    step(0, 0, 0, 0,  8, 7, 2'b00, 0, 0, 0,  1, 3, 0, 1);
    step(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1);
    step(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1);
    // x0 never forwards or stalls; unused port never stalls
    step(1, 0, 1, 1,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1);
    step(1, 9, 1, 1,  0, 0, 2'b11, 0, 0, 0,  0, 0, 0, 1);
    step(1, 1, 1, 0,  9, 9, 2'b00, 0, 0, 0,  1, 1, 0, 1);
    step(0, 0, 0, 0,  9, 0, 2'b01, 0, 0, 0,  2, 0, 0, 1);
    step(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1);
    // flush kills ID and EX; the MEM writer still advances to WB
    step(1, 6, 1, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1);
    step(1, 3, 1, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1);
    step(1, 4, 1, 0,  3, 6, 2'b00, 0, 1, 0,  1, 2, 0, 1);
    step(0, 0, 0, 0,  3, 6, 2'b00, 0, 0, 0,  0, 3, 0, 1);
    step(0, 0, 0, 0,  4, 3, 2'b00, 0, 0, 0,  0, 0, 0, 1);
    // hold freezes state (and beats flush), then release gives one stall
    step(1, 7, 1, 1,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1);
    step(1, 8, 1, 0,  7, 0, 2'b01, 1, 0, 0,  1, 0, 0, 1);
    step(1, 8, 1, 0,  7, 0, 2'b01, 1, 1, 0,  1, 0, 0, 1);
    step(1, 8, 1, 0,  7, 0, 2'b01, 1, 0, 0,  1, 0, 0, 1);
    step(1, 8, 1, 0,  7, 0, 2'b01, 0, 0, 0,  1, 0, 1, 1);
    step(1, 8, 1, 0,  7, 0, 2'b01, 0, 0, 0,  2, 0, 0, 2);
    // reset asserted during a stall cycle
    step(1, 9, 1, 1,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 2);
    step(1, 10, 1, 0, 9, 0, 2'b01, 0, 0, 1,  1, 0, 1, 2);
    step(1, 10, 1, 0, 9, 0, 2'b01, 0, 0, 0,  0, 0, 0, 0);
    step(0, 0, 0, 0, 10, 0, 2'b01, 0, 0, 0,  1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
